// File: rtl/serial_frame_ctrl.sv
// serial_frame_ctrl
//   Upstream controller for the 1-to-4 serial port demux. Parses a serial
//   frame from ser_in: start bit (0), PORT_W-bit port number (MSB first),
//   LEN_W-bit payload length (MSB first), then that many payload bits.
//   The parsed port number is registered on portnum and held across the
//   payload. Payload bits are passed through on ser_out with ser_valid.
//   done pulses for one cycle at the end of every frame.
//
// Ports
//   clk        in   1       rising-edge clock
//   rst        in   1       synchronous, active-high reset
//   ser_in     in   1       serial line, idles high, one bit per clk
//   portnum    out  PORT_W  selected port (registered demux select)
//   ser_out    out  1       payload bit (ser_in gated by ser_valid)
//   ser_valid  out  1       high during payload-bit cycles
//   busy       out  1       high in every state except IDLE
//   done       out  1       one-cycle pulse after the last payload bit
module serial_frame_ctrl #(
    parameter int PORT_W = 2,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ser_in,
    output logic [PORT_W-1:0] portnum,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              done
);

    // Field-bit counter must index the longer of the two header fields.
    localparam int FLD_MAX = (PORT_W > LEN_W) ? PORT_W : LEN_W;
    localparam int FCNT_W  = $clog2(FLD_MAX + 1);

    localparam logic [FCNT_W-1:0] PORT_LAST = FCNT_W'(PORT_W - 1);
    localparam logic [FCNT_W-1:0] LEN_LAST  = FCNT_W'(LEN_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PORT,
        S_LEN,
        S_DATA,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [PORT_W-1:0]   psh_q, psh_d;
    logic [PORT_W-1:0]   portnum_q, portnum_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic [PORT_W-1:0]   port_next;
    logic [LEN_W-1:0]    len_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            psh_q     <= '0;
            portnum_q <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            fcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            psh_q     <= psh_d;
            portnum_q <= portnum_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            fcnt_q    <= fcnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        psh_d     = psh_q;
        portnum_d = portnum_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        fcnt_d    = fcnt_q;
        // MSB-first shift: the incoming bit enters at the LSB.
        port_next = (psh_q << 1) | PORT_W'(ser_in);
        len_next  = (len_q << 1) | LEN_W'(ser_in);

        unique case (state_q)
            S_IDLE: begin
                if (!ser_in) begin
                    state_d = S_PORT;
                    fcnt_d  = '0;
                end
            end
            S_PORT: begin
                psh_d = port_next;
                if (fcnt_q == PORT_LAST) begin
                    portnum_d = port_next;
                    fcnt_d    = '0;
                    state_d   = S_LEN;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            S_LEN: begin
                len_d = len_next;
                if (fcnt_q == LEN_LAST) begin
                    fcnt_d = '0;
                    cnt_d  = len_next;
                    state_d = (len_next == '0) ? S_DONE : S_DATA;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            S_DATA: begin
                // The cycle that sees cnt_q==1 carries the final payload bit.
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // ser_in is deliberately ignored here; a 0 is not a start bit.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs come only from registered state so they never glitch
    // with ser_in; only ser_out follows the line combinationally.
    always_comb begin
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        if (state_q == S_DATA) ser_valid = 1'b1;
        if (state_q != S_IDLE) busy      = 1'b1;
        if (state_q == S_DONE) done      = 1'b1;
    end

    assign ser_out = ser_valid & ser_in;
    assign portnum = portnum_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
module tb_serial_frame_ctrl;

    logic       clk;
    logic       rst;
    logic       ser_in;
    logic [1:0] portnum;
    logic       ser_out;
    logic       ser_valid;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    serial_frame_ctrl #(.PORT_W(2), .LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ser_in    (ser_in),
        .portnum   (portnum),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive ser_in/rst just after the rising edge, then
    // check {portnum, ser_valid, ser_out, busy, done} at the falling edge.
    // ef = {ser_valid, ser_out, busy, done}.
    task automatic cyc(input logic b, input logic r, input logic [1:0] ep,
                       input logic [3:0] ef, input string tag);
        @(posedge clk);
        #1;
        ser_in = b;
        rst    = r;
        @(negedge clk);
        chk(tag, {26'd0, portnum, ser_valid, ser_out, busy, done}, {26'd0, ep, ef});
    endtask

    // Frame from test 1: start, port=10, len=0011, payload 1,0,1.
    logic       f1_in [0:9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] f1_fl [0:9] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                                4'b0010, 4'b0010, 4'b1110, 4'b1010, 4'b1110};

    // Runs cycles 0..last of the test-1 frame; p0 is portnum before the load.
    task automatic frame1(input logic [1:0] p0, input int last, input string pfx);
        for (int i = 0; i <= last; i++) begin
            cyc(f1_in[i], 1'b0, (i < 3) ? p0 : 2'd2, f1_fl[i], $sformatf("%s_c%0d", pfx, i));
        end
    endtask

    // Empty frame: start, port=11, len=0000, done at cycle 7.
    task automatic frame_empty(input logic [1:0] p0, input string pfx);
        cyc(1'b0, 1'b0, p0, 4'b0000, {pfx, "_c0"});
        cyc(1'b1, 1'b0, p0, 4'b0010, {pfx, "_c1"});
        cyc(1'b1, 1'b0, p0, 4'b0010, {pfx, "_c2"});
        for (int i = 3; i <= 6; i++) cyc(1'b0, 1'b0, 2'd3, 4'b0010, $sformatf("%s_c%0d", pfx, i));
        cyc(1'b1, 1'b0, 2'd3, 4'b0011, {pfx, "_done"});
        cyc(1'b1, 1'b0, 2'd3, 4'b0000, {pfx, "_idle"});
    endtask

    initial begin
        rst    = 1'b1;
        ser_in = 1'b1;
        repeat (2) @(posedge clk);
        cyc(1'b1, 1'b0, 2'd0, 4'b0000, "reset");
        cyc(1'b1, 1'b0, 2'd0, 4'b0000, "reset_idle");

        // Test 1: basic 3-bit payload to port 2
        frame1(2'd0, 9, "t1");
        cyc(1'b1, 1'b0, 2'd2, 4'b0011, "t1_done");
        cyc(1'b1, 1'b0, 2'd2, 4'b0000, "t1_idle");

        // Test 2: empty frame to port 3
        frame_empty(2'd2, "t2");

        // Test 3: port 1, maximum length 15, alternating payload 1,0,1,...
        cyc(1'b0, 1'b0, 2'd3, 4'b0000, "t3_c0");
        cyc(1'b0, 1'b0, 2'd3, 4'b0010, "t3_c1");
        cyc(1'b1, 1'b0, 2'd3, 4'b0010, "t3_c2");
        for (int i = 3; i <= 6; i++) cyc(1'b1, 1'b0, 2'd1, 4'b0010, $sformatf("t3_c%0d", i));
        for (int i = 0; i < 15; i++) begin
            logic bv;
            bv = (i % 2 == 0) ? 1'b1 : 1'b0;
            cyc(bv, 1'b0, 2'd1, {1'b1, bv, 2'b10}, $sformatf("t3_c%0d", i + 7));
        end
        cyc(1'b1, 1'b0, 2'd1, 4'b0011, "t3_done_c22");
        cyc(1'b1, 1'b0, 2'd1, 4'b0000, "t3_idle");

        // Test 4: idle line for 50 cycles
        for (int i = 0; i < 50; i++) cyc(1'b1, 1'b0, 2'd1, 4'b0000, $sformatf("t4_c%0d", i));

        // Test 5: reset on the 2nd payload bit, then a fresh frame
        frame1(2'd1, 7, "t5");
        cyc(1'b0, 1'b1, 2'd2, 4'b1010, "t5_c8_rst");
        cyc(1'b1, 1'b0, 2'd0, 4'b0000, "t5_after_rst");
        cyc(1'b1, 1'b0, 2'd0, 4'b0000, "t5_nodone1");
        cyc(1'b1, 1'b0, 2'd0, 4'b0000, "t5_nodone2");
        frame_empty(2'd0, "t5b");

        // Test 6: back-to-back frames, 0 during DONE ignored
        frame1(2'd3, 9, "t6");
        cyc(1'b0, 1'b0, 2'd2, 4'b0011, "t6_done0");
        cyc(1'b0, 1'b0, 2'd2, 4'b0000, "t6_start2");
        cyc(1'b0, 1'b0, 2'd2, 4'b0010, "t6_p1");
        cyc(1'b1, 1'b0, 2'd2, 4'b0010, "t6_p2");
        cyc(1'b0, 1'b0, 2'd1, 4'b0010, "t6_l1");
        cyc(1'b0, 1'b0, 2'd1, 4'b0010, "t6_l2");
        cyc(1'b0, 1'b0, 2'd1, 4'b0010, "t6_l3");
        cyc(1'b1, 1'b0, 2'd1, 4'b0010, "t6_l4");
        cyc(1'b1, 1'b0, 2'd1, 4'b1110, "t6_data");
        cyc(1'b1, 1'b0, 2'd1, 4'b0011, "t6_done2");
        cyc(1'b1, 1'b0, 2'd1, 4'b0000, "t6_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
